// File: rtl/nios_pio_pkg.sv
// Shared constants for the PIO family: register offsets, edge-capture modes and IRQ sources.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/nios_pio_sync.sv
// Multi-bit flop-chain synchroniser; dout is din delayed STAGES clocks.
// Synchronous active-high reset clears every stage.
module nios_pio_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], din};
    end
  end

  assign dout = stage[STAGES-1];

endmodule

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, sticky edge capture, IRQ mask and registered IRQ.
// Read latency 1 cycle; no wait states, the slave never stalls the master.
module nios_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_MODE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam int ARM_COUNT = SYNC_STAGES + 1;
  localparam int CW        = $clog2(ARM_COUNT + 1);

  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] capture;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] evt;
  logic [DATA_WIDTH-1:0] clr;
  logic [CW-1:0]         arm_cnt;
  logic                  armed;
  logic                  wr;
  logic [31:0]           rd_mux;
  logic                  irq_src;
  logic                  unused_wdata;

  nios_pio_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (in_port),
    .dout  (sync)
  );

  // The chain flushes its reset zeros for SYNC_STAGES+1 cycles; ignore edges until then.
  assign armed = (arm_cnt == CW'(ARM_COUNT));

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    evt = sync & ~prev;
    if (EDGE_TYPE == EDGE_FALL) begin
      evt = ~sync & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      evt = sync ^ prev;
    end
  end

  assign wr           = chipselect & ~write_n;
  assign clr          = (wr && address == ADDR_EDGE) ? writedata[DATA_WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(sync);
      ADDR_MASK: rd_mux = 32'(mask);
      ADDR_EDGE: rd_mux = 32'(capture);
      default:   rd_mux = '0;
    endcase
  end

  assign irq_src = (IRQ_MODE == IRQ_EDGE) ? |(capture & mask) : |(sync & mask);

  // A new event outranks a same-cycle W1C so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev     <= '0;
      capture  <= '0;
      mask     <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= sync;
      capture  <= (capture & ~clr) | (evt & {DATA_WIDTH{armed}});
      if (wr && address == ADDR_MASK) begin
        mask <= writedata[DATA_WIDTH-1:0];
      end
      readdata <= rd_mux;
      irq      <= irq_src;
    end
  end

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// Four DUT configurations share one bus; a queue-based model predicts readdata/irq each edge.
module tb_nios_pio_in_edge;

  localparam int DW = 16;
  localparam int S  = 2;
  localparam int NC = 4;
  // config:        c3    c2    c1    c0
  localparam logic [NC-1:0][1:0] ET = {2'd0, 2'd2, 2'd1, 2'd0};
  localparam logic [NC-1:0]      IM = 4'b0111;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [DW-1:0] in_port;
  logic [31:0]   rd    [NC];
  logic          irq_o [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    nios_pio_in_edge #(
      .DATA_WIDTH  (DW),
      .SYNC_STAGES (S),
      .EDGE_TYPE   (int'(ET[g])),
      .IRQ_MODE    (int'(IM[g]))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (rd[g]),
      .irq        (irq_o[g])
    );
  end

  typedef struct {
    int                   stamp;
    logic [NC-1:0][31:0]  rd;
    logic [NC-1:0]        irq;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  // Reference model state: input delay line, edges since reset, registers.
  logic [DW-1:0] m_hist[$];
  logic [DW-1:0] m_sync, m_prev, m_mask;
  logic [DW-1:0] m_cap [NC];
  int            m_since;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic predict();
    exp_t          e;
    logic [DW-1:0] ev, clr;
    bit            wr;
    e.stamp = edge_cnt + 1;
    e.rd    = '0;
    e.irq   = '0;
    if (reset) begin
      m_sync  = '0;
      m_prev  = '0;
      m_mask  = '0;
      m_since = 0;
      for (int c = 0; c < NC; c++) m_cap[c] = '0;
      m_hist.delete();
      for (int i = 0; i < S - 1; i++) m_hist.push_back('0);
    end else begin
      for (int c = 0; c < NC; c++) begin
        case (address)
          2'd0:    e.rd[c] = {16'h0, m_sync};
          2'd2:    e.rd[c] = {16'h0, m_mask};
          2'd3:    e.rd[c] = {16'h0, m_cap[c]};
          default: e.rd[c] = 32'h0;
        endcase
        e.irq[c] = IM[c] ? |(m_cap[c] & m_mask) : |(m_sync & m_mask);
      end
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[DW-1:0] : '0;
      for (int c = 0; c < NC; c++) begin
        case (ET[c])
          2'd0:    ev = m_sync & ~m_prev;
          2'd1:    ev = ~m_sync & m_prev;
          default: ev = m_sync ^ m_prev;
        endcase
        if (m_since < S + 1) ev = '0;
        m_cap[c] = (m_cap[c] & ~clr) | ev;
      end
      if (wr && address == 2'd2) m_mask = writedata[DW-1:0];
      m_prev = m_sync;
      m_hist.push_back(in_port);
      m_sync = m_hist.pop_front();
      if (m_since < S + 1) m_since++;
    end
    sb.push_back(e);
  endtask

  // Monitor: every edge the DUTs present readdata/irq; pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].stamp < edge_cnt) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_stale: entry for edge %0d still queued at edge %0d", sb[0].stamp, edge_cnt);
      void'(sb.pop_front());
    end else if (sb.size() > 0 && sb[0].stamp == edge_cnt) begin
      e = sb.pop_front();
      for (int c = 0; c < NC; c++) begin
        n_cmp++;
        if (rd[c] !== e.rd[c]) begin
          n_bad++;
          $display("FAIL readdata cfg%0d edge %0d: got %h want %h", c, edge_cnt, rd[c], e.rd[c]);
        end
        n_cmp++;
        if (irq_o[c] !== e.irq[c]) begin
          n_bad++;
          $display("FAIL irq cfg%0d edge %0d: got %b want %b", c, edge_cnt, irq_o[c], e.irq[c]);
        end
      end
    end
  end

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wr_cycle(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_cycle(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 16'hFFFF;

    // 1: inputs high through reset must not register as edges
    repeat (3) tick();
    reset = 1'b0;
    repeat (10) tick();
    rd_cycle(2'd3);
    chk("t1_cap", rd[0], 32'h0);
    chk("t1_irq", 32'(irq_o[0]), 32'h0);
    rd_cycle(2'd0);
    chk("t1_data", rd[0], 32'h0000FFFF);
    rd_cycle(2'd1);
    chk("t1_rsvd", rd[0], 32'h0);

    // 2: rising edge on bit0 with mask bit0, then W1C
    wr_cycle(2'd2, 32'h0001);
    in_port = 16'h0000;
    repeat (6) tick();
    wr_cycle(2'd3, 32'hFFFF);
    in_port = 16'h0001;
    repeat (S + 2) tick();
    chk("t2_cap", rd[0], 32'h1);
    chk("t2_irq", 32'(irq_o[0]), 32'h1);
    wr_cycle(2'd3, 32'h1);
    tick();
    chk("t2_clr_cap", rd[0], 32'h0);
    chk("t2_clr_irq", 32'(irq_o[0]), 32'h0);

    // 3: falling-only capture on bit3; any-edge bit5 stays sticky
    wr_cycle(2'd3, 32'hFFFF);
    in_port[3] = 1'b1;
    repeat (5) tick();
    chk("t3_fall_on_rise", 32'(rd[1][3]), 32'h0);
    in_port[3] = 1'b0;
    repeat (5) tick();
    chk("t3_fall_on_fall", 32'(rd[1][3]), 32'h1);
    wr_cycle(2'd3, 32'hFFFF);
    in_port[5] = 1'b1;
    repeat (5) tick();
    chk("t3_any_first", 32'(rd[2][5]), 32'h1);
    in_port[5] = 1'b0;
    repeat (5) tick();
    chk("t3_any_sticky", 32'(rd[2][5]), 32'h1);

    // 4: W1C of bit2 lands on the same edge as bit2's rising event
    wr_cycle(2'd3, 32'hFFFF);
    repeat (2) tick();
    in_port[2] = 1'b1;
    tick();
    repeat (S - 1) tick();
    wr_cycle(2'd3, 32'h4);
    tick();
    chk("t4_event_wins", 32'(rd[0][2]), 32'h1);
    chk("t4_fall_cleared", 32'(rd[1][2]), 32'h0);

    // 5: level IRQ follows synchronised bit15
    wr_cycle(2'd2, 32'h8000);
    in_port[15] = 1'b1;
    repeat (4) tick();
    chk("t5_level_on", 32'(irq_o[3]), 32'h1);
    in_port[15] = 1'b0;
    repeat (S) tick();
    chk("t5_level_hold", 32'(irq_o[3]), 32'h1);
    tick();
    chk("t5_level_off", 32'(irq_o[3]), 32'h0);

    // 6: reset mid-operation with capture and mask populated
    wr_cycle(2'd3, 32'hFFFF);
    wr_cycle(2'd2, 32'hFFFF);
    in_port = in_port | 16'h00F0;
    repeat (5) tick();
    address = 2'd3;
    tick();
    chk("t6_cap_before", rd[0], 32'h00F0);
    chk("t6_irq_before", 32'(irq_o[0]), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rd_after", rd[0], 32'h0);
    chk("t6_irq_after", 32'(irq_o[0]), 32'h0);
    rd_cycle(2'd2);
    chk("t6_mask_after", rd[0], 32'h0);
    address = 2'd3;
    repeat (8) tick();
    chk("t6_rearm", rd[0], 32'h0);

    // Randomised traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 2) != 0);
      writedata  = $urandom;
      in_port    = in_port ^ 16'($urandom & $urandom & $urandom);
      tick();
    end
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
